dispense_sequencer: RTL and testbench
=====================================

Name: dispense_sequencer

Overview:
- Timed controller that drives the beverage machine's ingredient valves (agua, cafe, leche, chocolate, azucar) once payment and selection are complete.
- The upstream payment/selection FSM issues a one-cycle start with a drink code and sugar level. This block runs the recipe as a fixed phase sequence, opening one valve at a time for a recipe-defined number of time units.
- It reports busy/done/aborted back to the upstream FSM.

Parameters:
- TICK_DIV, 50, clock cycles per time unit; 1 s at the board clock, small values for simulation; must be >= 2.
- SUGAR_MAX, 3, highest accepted sugar level; larger inputs saturate to this value.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- drink  in  2  0 espresso, 1 latte, 2 mocha, 3 chocolate; sampled at accept
- sugar  in  2  sugar units 0..3; sampled at accept
- abort  in  1  cancel the running recipe
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse when a recipe completes
- aborted  out  1  one-cycle pulse when abort takes effect
- agua, cafe, leche, chocolate, azucar  out  1 each  valve enables, registered
- phase  out  3  current phase code
- secs  out  4  whole time units remaining in the current phase

Behaviour:
- Reset (async, reset=0): state IDLE, every output 0, prescaler and duration counter 0, latched drink/sugar 0. All valves close immediately, without waiting for a clock edge.
- Phases, in this order: IDLE(0), SUGAR(1), WATER(2), COFFEE(3), MILK(4), CHOC(5), DONE(6).
- Durations in time units, listed as espresso/latte/mocha/chocolate:
  - SUGAR = latched sugar
  - WATER = 2/2/2/2
  - COFFEE = 3/2/2/0
  - MILK = 0/3/1/2
  - CHOC = 0/0/2/3
- Phase selection:
  - Any phase whose duration is 0 is skipped with no cycle cost.
  - The next-phase selector picks the first later phase with a nonzero duration, or DONE if none remain.
- Accept: on an edge with state IDLE, start=1 and abort=0:
  - latch drink and sugar;
  - clear the prescaler;
  - enter the first nonzero phase and load secs with its duration.
- Valves:
  - Exactly one valve is high in each active phase: SUGAR->azucar, WATER->agua, COFFEE->cafe, MILK->leche, CHOC->chocolate.
  - No valve is high in IDLE or DONE. Two valves are never high together.
- Timing and latency:
  - The valve for the first phase is high on the cycle after the accepting edge.
  - A phase of duration d keeps its valve high for exactly d*TICK_DIV cycles.
  - The prescaler counts 0..TICK_DIV-1; a tick fires when it reaches TICK_DIV-1.
  - Each tick decrements secs. When secs would reach 0, the next phase is entered on the same edge, so there is no gap cycle between valves.
- DONE: lasts one cycle with done=1, then IDLE.
- busy: high from the cycle after accept through the DONE cycle, inclusive.
- start while busy: ignored. drink/sugar changes after accept have no effect.
- abort in any non-IDLE state, DONE included:
  - next edge: state IDLE, all valves 0, aborted=1 for one cycle, done not asserted;
  - an abort arriving in the same cycle as the DONE transition wins.
- abort in IDLE: no effect. If start and abort are both high in IDLE, the start is dropped.
- phase/secs: in IDLE they read 0 and 0; in DONE they read 6 and 0.

Decomposition:
- Package dispense_pkg holds:
  - phase_t enum (3-bit codes above);
  - drink_t enum;
  - the recipe duration table as a constant array indexed [phase][drink];
  - a function next_phase(cur, drink, sugar) returning phase_t.
- Sub-module tick_prescaler, parameter TICK_DIV, with ports clk, reset, clr, tick. It is reused by the machine's other timed blocks.

Test Plan:
All runs use TICK_DIV=4, with the accepting edge numbered cycle 0.
1. Espresso, sugar=1 -> azucar cycles 1-4, agua 5-12, cafe 13-24, done pulse at 25, busy 1-25, IDLE at 26; leche and chocolate never high.
2. Mocha, sugar=0 -> SUGAR skipped; agua 1-8, cafe 9-16, leche 17-20, chocolate 21-28, done at 29; secs steps 2,1 during agua.
3. Latte, sugar=2, abort pulsed at cycle 15 (inside WATER, agua high) -> cycle 16: all valves 0, aborted=1, busy=0; done never pulses; a new start at 18 is accepted normally.
4. Chocolate, sugar=3; at cycle 6 assert start again with drink=0 -> second start ignored. Sequence stays azucar 12 cycles, agua 8, leche 8, chocolate 12; done at 41.
5. Espresso running; drive reset=0 between clock edges at cycle 7 -> agua falls immediately with no edge; after release, busy=0 and all outputs 0.
6. In IDLE, start=1 and abort=1 in the same cycle -> no state change, busy stays 0, aborted stays 0.

Source files
------------

// File: rtl/dispense_pkg.sv
// dispense_pkg: phase/drink encodings, recipe duration table and next-phase selector
package dispense_pkg;
  typedef enum logic [2:0] {
    P_IDLE   = 3'd0,
    P_SUGAR  = 3'd1,
    P_WATER  = 3'd2,
    P_COFFEE = 3'd3,
    P_MILK   = 3'd4,
    P_CHOC   = 3'd5,
    P_DONE   = 3'd6
  } phase_t;
  typedef enum logic [1:0] {D_ESPRESSO, D_LATTE, D_MOCHA, D_CHOCOLATE} drink_t;
  // [phase][drink]; the SUGAR row is unused because its duration is the latched sugar level
  localparam logic [3:0] DUR_TBL [8][4] = '{
    '{4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd2, 4'd2, 4'd2, 4'd2},
    '{4'd3, 4'd2, 4'd2, 4'd0},
    '{4'd0, 4'd3, 4'd1, 4'd2},
    '{4'd0, 4'd0, 4'd2, 4'd3},
    '{4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd0, 4'd0, 4'd0, 4'd0}
  };
  function automatic logic [3:0] duration(phase_t p, drink_t d, logic [1:0] s);
    return p == P_SUGAR ? {2'b00, s} : DUR_TBL[p][d];
  endfunction
  function automatic phase_t next_phase(phase_t cur, drink_t d, logic [1:0] s);
    phase_t n;
    n = P_DONE;
    for (int i = 5; i >= 1; i--)
      if (3'(i) > cur && duration(phase_t'(3'(i)), d, s) != 4'd0) n = phase_t'(3'(i));
    return n;
  endfunction
endpackage

// File: rtl/dispense_sequencer_if.sv
// dispense_sequencer_if: request/status/valve bundle between the upstream FSM and the sequencer
interface dispense_sequencer_if;
  import dispense_pkg::*;
  logic start;
  drink_t drink;
  logic [1:0] sugar;
  logic abort;
  logic busy;
  logic done;
  logic aborted;
  logic agua;
  logic cafe;
  logic leche;
  logic chocolate;
  logic azucar;
  phase_t phase;
  logic [3:0] secs;
  modport master(output start, drink, sugar, abort,
                 input busy, done, aborted, agua, cafe, leche, chocolate, azucar, phase, secs);
  modport slave(input start, drink, sugar, abort,
                output busy, done, aborted, agua, cafe, leche, chocolate, azucar, phase, secs);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick
module tick_prescaler #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/dispense_sequencer.sv
// dispense_sequencer: runs a drink recipe as a timed phase sequence, one valve open at a time
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int TICK_DIV  = 50,
  parameter int SUGAR_MAX = 3
) (
  input logic clk,
  input logic reset,
  dispense_sequencer_if.slave bus
);
  phase_t state, state_n;
  drink_t drink_l, drink_n;
  logic [1:0] sugar_l, sugar_n, sugar_in;
  logic [3:0] secs_n;
  logic aborted_n, tick;
  assign sugar_in = bus.sugar > 2'(SUGAR_MAX) ? 2'(SUGAR_MAX) : bus.sugar;
  assign bus.phase = state;
  // idle holds the prescaler at 0, so the first phase starts on a fresh time unit
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk(clk),
    .reset(reset),
    .clr(state == P_IDLE),
    .tick(tick)
  );
  always_comb begin
    state_n = state;
    secs_n = bus.secs;
    drink_n = drink_l;
    sugar_n = sugar_l;
    aborted_n = 1'b0;
    if (state == P_IDLE) begin
      if (bus.start && !bus.abort) begin
        drink_n = bus.drink;
        sugar_n = sugar_in;
        state_n = next_phase(P_IDLE, bus.drink, sugar_in);
        secs_n = duration(state_n, bus.drink, sugar_in);
      end
    end else if (bus.abort) begin
      state_n = P_IDLE;
      secs_n = 4'd0;
      aborted_n = 1'b1;
    end else if (state == P_DONE) begin
      state_n = P_IDLE;
      secs_n = 4'd0;
    end else if (tick) begin
      state_n = bus.secs == 4'd1 ? next_phase(state, drink_l, sugar_l) : state;
      secs_n = bus.secs == 4'd1 ? duration(state_n, drink_l, sugar_l) : bus.secs - 4'd1;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= P_IDLE;
      drink_l <= D_ESPRESSO;
      sugar_l <= 2'd0;
      bus.secs <= 4'd0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.aborted <= 1'b0;
      bus.azucar <= 1'b0;
      bus.agua <= 1'b0;
      bus.cafe <= 1'b0;
      bus.leche <= 1'b0;
      bus.chocolate <= 1'b0;
    end else begin
      state <= state_n;
      drink_l <= drink_n;
      sugar_l <= sugar_n;
      bus.secs <= secs_n;
      bus.busy <= state_n != P_IDLE;
      bus.done <= state_n == P_DONE;
      bus.aborted <= aborted_n;
      bus.azucar <= state_n == P_SUGAR;
      bus.agua <= state_n == P_WATER;
      bus.cafe <= state_n == P_COFFEE;
      bus.leche <= state_n == P_MILK;
      bus.chocolate <= state_n == P_CHOC;
    end
endmodule

// File: tb/tb_dispense_sequencer.sv
// tb_dispense_sequencer: directed plan plus random traffic against a recipe-schedule model
module tb_dispense_sequencer;
  import dispense_pkg::*;
  localparam int TD = 4;
  typedef struct packed {
    logic agua, cafe, leche, chocolate, azucar, busy, done, aborted;
    logic [2:0] phase;
    logic [3:0] secs;
  } obs_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  obs_t cur, q[$];
  dispense_sequencer_if bus();
  dispense_sequencer #(.TICK_DIV(TD), .SUGAR_MAX(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic obs_t dut_obs();
    return {bus.agua, bus.cafe, bus.leche, bus.chocolate, bus.azucar, bus.busy, bus.done,
            bus.aborted, 3'(bus.phase), bus.secs};
  endfunction
  // expected per-cycle outputs for a whole recipe, straight from the recipe table
  task automatic build(input int d, input int s);
    int dur[6];
    obs_t e;
    dur[0] = 0;
    dur[1] = s > 3 ? 3 : s;
    dur[2] = 2;
    dur[3] = d == 0 ? 3 : d == 3 ? 0 : 2;
    dur[4] = d == 1 ? 3 : d == 2 ? 1 : d == 3 ? 2 : 0;
    dur[5] = d == 2 ? 2 : d == 3 ? 3 : 0;
    for (int p = 1; p <= 5; p++)
      for (int k = 0; k < dur[p] * TD; k++) begin
        e = '0;
        e.phase = 3'(p);
        e.secs = 4'(dur[p] - k / TD);
        e.busy = 1'b1;
        e.azucar = p == 1;
        e.agua = p == 2;
        e.cafe = p == 3;
        e.leche = p == 4;
        e.chocolate = p == 5;
        q.push_back(e);
      end
    e = '0;
    e.phase = 3'd6;
    e.busy = 1'b1;
    e.done = 1'b1;
    q.push_back(e);
  endtask
  always @(posedge clk or negedge reset) begin
    obs_t e;
    if (!reset) begin
      q.delete();
      cur = '0;
    end else begin
      if (!cur.busy) begin
        if (bus.start && !bus.abort) build(int'(bus.drink), int'(bus.sugar));
      end else if (bus.abort) begin
        q.delete();
        e = '0;
        e.aborted = 1'b1;
        q.push_back(e);
      end
      cur = q.size() != 0 ? q.pop_front() : obs_t'('0);
    end
  end
  always @(negedge clk) begin
    n_cmp++;
    if (dut_obs() !== cur) begin
      n_bad++;
      $display("FAIL cycle_cmp t=%0t got %h expected %h", $time, dut_obs(), cur);
    end
  end
  task automatic lit(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
      bus.drink = drink_t'($urandom_range(0, 3));
      bus.sugar = 2'($urandom_range(0, 3));
    end
  endtask
  task automatic go(input int d, input int s);
    bus.drink = drink_t'(2'(d));
    bus.sugar = 2'(s);
    bus.start = 1'b1;
    cyc = 0;
    @(negedge clk);
    cyc = 1;
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.drink = D_ESPRESSO;
    bus.sugar = 2'd0;
    repeat (3) @(negedge clk);
    lit("reset_busy", bus.busy, 0);
    lit("reset_obs", int'(dut_obs()), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    go(0, 1);
    lit("t1_azucar_c1", bus.azucar, 1);
    lit("t1_secs_c1", bus.secs, 1);
    wait_to(5);
    lit("t1_agua_c5", bus.agua, 1);
    lit("t1_azucar_c5", bus.azucar, 0);
    wait_to(13);
    lit("t1_cafe_secs_c13", bus.secs, 3);
    wait_to(25);
    lit("t1_done_c25", bus.done, 1);
    lit("t1_phase_c25", bus.phase, 6);
    wait_to(26);
    lit("t1_busy_c26", bus.busy, 0);
    wait_to(28);
    go(2, 0);
    lit("t2_agua_c1", bus.agua, 1);
    lit("t2_secs_c1", bus.secs, 2);
    wait_to(5);
    lit("t2_secs_c5", bus.secs, 1);
    wait_to(17);
    lit("t2_leche_c17", bus.leche, 1);
    wait_to(21);
    lit("t2_choc_c21", bus.chocolate, 1);
    wait_to(29);
    lit("t2_done_c29", bus.done, 1);
    wait_to(32);
    go(1, 2);
    wait_to(15);
    lit("t3_agua_c15", bus.agua, 1);
    bus.abort = 1'b1;
    wait_to(16);
    bus.abort = 1'b0;
    lit("t3_aborted_c16", bus.aborted, 1);
    lit("t3_busy_c16", bus.busy, 0);
    lit("t3_agua_c16", bus.agua, 0);
    wait_to(18);
    go(0, 1);
    lit("t3_restart_azucar", bus.azucar, 1);
    wait_to(28);
    go(3, 3);
    wait_to(6);
    bus.start = 1'b1;
    bus.drink = D_ESPRESSO;
    wait_to(7);
    bus.start = 1'b0;
    wait_to(13);
    lit("t4_agua_c13", bus.agua, 1);
    wait_to(21);
    lit("t4_leche_c21", bus.leche, 1);
    wait_to(29);
    lit("t4_choc_c29", bus.chocolate, 1);
    wait_to(41);
    lit("t4_done_c41", bus.done, 1);
    wait_to(44);
    go(0, 0);
    wait_to(7);
    lit("t5_agua_c7", bus.agua, 1);
    #2 reset = 1'b0;
    #1 lit("t5_agua_async", bus.agua, 0);
    lit("t5_busy_async", bus.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    lit("t5_obs_after", int'(dut_obs()), 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    lit("t6_busy", bus.busy, 0);
    lit("t6_aborted", bus.aborted, 0);
    for (int i = 0; i < 4000; i++) begin
      bus.start = $urandom_range(0, 5) == 0;
      bus.abort = $urandom_range(0, 49) == 0;
      bus.drink = drink_t'($urandom_range(0, 3));
      bus.sugar = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
